// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants, FSM state encoding and the injection helper
// for the serial Hamming(7,4) transmitter.
//   N, K, R       : codeword, data and parity widths
//   PAR_P*        : codeword indices that hold parity (positions 1, 2, 4)
//   state_t       : transmitter FSM states
//   inject_flip() : flips code[pos-1] when pos != 0
package hamming_pkg;
   localparam int N = 7;
   localparam int K = 4;
   localparam int R = 3;

   localparam int PAR_P1 = 0;
   localparam int PAR_P2 = 1;
   localparam int PAR_P4 = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Position 0 means "no injection". Any other 3-bit value is a legal
   // 1-based codeword position.
   function automatic logic [N-1:0] inject_flip(input logic [N-1:0] c,
                                                input logic [R-1:0] pos);
      logic [N-1:0] m;
      m = '0;
      if (pos != '0) m[pos - 3'd1] = 1'b1;
      return c ^ m;
   endfunction
endpackage

// File: rtl/hamming_tx_if.sv
// hamming_tx_if: word input handshake plus serial output bundle.
//   w, in_valid, inject_pos : word, its valid, fault position (master drives)
//   in_ready                : transmitter can accept (slave drives)
//   tx_bit, tx_valid, tx_sof: serial stream (slave drives)
//   code, frame_count       : last codeword and completed-frame count
interface hamming_tx_if;
   import hamming_pkg::*;

   logic [K-1:0] w;
   logic         in_valid;
   logic         in_ready;
   logic [R-1:0] inject_pos;
   logic         tx_bit;
   logic         tx_valid;
   logic         tx_sof;
   logic [N-1:0] code;
   logic [7:0]   frame_count;

   modport master (
      output w, in_valid, inject_pos,
      input  in_ready, tx_bit, tx_valid, tx_sof, code, frame_count
   );

   modport slave (
      input  w, in_valid, inject_pos,
      output in_ready, tx_bit, tx_valid, tx_sof, code, frame_count
   );
endinterface

// File: rtl/hamming_encoder_comb.sv
// hamming_encoder_comb: combinational Hamming(7,4) encoder.
//   w [3:0] : data word
//   c [6:0] : codeword, c[i] is position i+1; parity at positions 1, 2, 4
// The data placement is the inverse of the decoder's data extraction, so the
// decoder syndrome equals the position of any single flipped bit.
module hamming_encoder_comb
   import hamming_pkg::*;
(
   input  logic [K-1:0] w,
   output logic [N-1:0] c
);

   always_comb begin
      c         = '0;
      c[6:4]    = w[3:1];
      c[2]      = w[0];
      c[PAR_P1] = w[0] ^ w[1] ^ w[3];   // covers positions 3,5,7
      c[PAR_P2] = w[0] ^ w[2] ^ w[3];   // covers positions 3,6,7
      c[PAR_P4] = w[1] ^ w[2] ^ w[3];   // covers positions 5,6,7
   end

endmodule

// File: rtl/hamming_tx.sv
// hamming_tx: serial Hamming(7,4) transmitter.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : hamming_tx_if.slave (word handshake in, serial stream out)
// Parameters:
//   GAP_CYCLES : idle cycles after each frame (0..7)
//   LSB_FIRST  : 1 sends code[0] first, 0 sends code[6] first
// A word is accepted in IDLE, encoded (plus optional single-bit flip) and
// shifted out over 7 cycles, followed by GAP_CYCLES idle cycles.
module hamming_tx
   import hamming_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter bit LSB_FIRST  = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   hamming_tx_if.slave bus
);

   localparam logic [2:0] LAST_BIT = 3'(N - 1);
   localparam logic [2:0] LAST_GAP = 3'(GAP_CYCLES - 1);

   state_t       state, state_n;
   logic [2:0]   bitcnt, bitcnt_n;
   logic [2:0]   gapcnt, gapcnt_n;
   logic [N-1:0] code_q, code_n;
   logic [N-1:0] enc_c;
   logic [7:0]   fcnt;
   logic         fc_inc;
   logic         tx_bit_q, tx_valid_q, tx_sof_q;
   logic         tx_bit_n, tx_valid_n, tx_sof_n;
   logic [2:0]   sel_n;

   hamming_encoder_comb u_enc (
      .w (bus.w),
      .c (enc_c)
   );

   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      gapcnt_n = gapcnt;
      code_n   = code_q;
      fc_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               code_n   = inject_flip(enc_c, bus.inject_pos);
               bitcnt_n = '0;
               state_n  = SEND;
            end
         end
         SEND: begin
            if (bitcnt == LAST_BIT) begin
               fc_inc   = 1'b1;
               bitcnt_n = '0;
               gapcnt_n = '0;
               state_n  = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               bitcnt_n = bitcnt + 3'd1;
            end
         end
         GAP: begin
            if (gapcnt == LAST_GAP) begin
               gapcnt_n = '0;
               state_n  = IDLE;
            end else begin
               gapcnt_n = gapcnt + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Serial outputs are registered from next-state values, so the first bit
   // appears in the cycle right after the accept edge.
   always_comb begin
      sel_n      = LSB_FIRST ? bitcnt_n : (LAST_BIT - bitcnt_n);
      tx_valid_n = (state_n == SEND);
      tx_bit_n   = tx_valid_n & code_n[sel_n];
      tx_sof_n   = tx_valid_n & (bitcnt_n == 3'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bitcnt     <= '0;
         gapcnt     <= '0;
         code_q     <= '0;
         fcnt       <= '0;
         tx_bit_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_sof_q   <= 1'b0;
      end else begin
         state      <= state_n;
         bitcnt     <= bitcnt_n;
         gapcnt     <= gapcnt_n;
         code_q     <= code_n;
         fcnt       <= fcnt + {7'd0, fc_inc};
         tx_bit_q   <= tx_bit_n;
         tx_valid_q <= tx_valid_n;
         tx_sof_q   <= tx_sof_n;
      end
   end

   // Ready is held low during reset, not only by the state register.
   assign bus.in_ready    = (state == IDLE) & ~rst;
   assign bus.tx_bit      = tx_bit_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.tx_sof      = tx_sof_q;
   assign bus.code        = code_q;
   assign bus.frame_count = fcnt;

endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: directed bench for hamming_tx. Three instances share clk/rst:
// ua (defaults), ub (LSB_FIRST=0), uc (GAP_CYCLES=0).
module tb_hamming_tx;
   import hamming_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errs = 0;
   int   nchk = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hamming_tx_if ia ();
   hamming_tx_if ib ();
   hamming_tx_if ic ();

   hamming_tx #(.GAP_CYCLES(1), .LSB_FIRST(1'b1)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
   hamming_tx #(.GAP_CYCLES(1), .LSB_FIRST(1'b0)) ub (.clk(clk), .rst(rst), .bus(ib.slave));
   hamming_tx #(.GAP_CYCLES(0), .LSB_FIRST(1'b1)) uc (.clk(clk), .rst(rst), .bus(ic.slave));

   logic [3:0] ref_w;
   logic [6:0] ref_c;
   hamming_encoder_comb u_ref (.w(ref_w), .c(ref_c));

   logic [2:0] rdy, txb, txv, txs;
   assign rdy = {ic.in_ready, ib.in_ready, ia.in_ready};
   assign txb = {ic.tx_bit,   ib.tx_bit,   ia.tx_bit};
   assign txv = {ic.tx_valid, ib.tx_valid, ia.tx_valid};
   assign txs = {ic.tx_sof,   ib.tx_sof,   ia.tx_sof};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [3:0] wv, input logic [2:0] ip);
      case (sel)
         0: begin ia.in_valid = v; ia.w = wv; ia.inject_pos = ip; end
         1: begin ib.in_valid = v; ib.w = wv; ib.inject_pos = ip; end
         default: begin ic.in_valid = v; ic.w = wv; ic.inject_pos = ip; end
      endcase
   endtask

   // Bounded wait at negedges for in_ready.
   task automatic wait_ready(input int sel);
      int n;
      n = 0;
      while (!rdy[sel] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[sel]) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   // Samples 7 consecutive cycles starting at the current negedge.
   task automatic collect(input int sel, output logic [6:0] s, output logic [6:0] sf,
                          output logic [6:0] v);
      for (int i = 0; i < 7; i++) begin
         s[i] = txb[sel];
         sf[i] = txs[sel];
         v[i] = txv[sel];
         if (i < 6) @(negedge clk);
      end
   endtask

   // Independent syndrome: bit-position parity checks over positions 1..7.
   function automatic logic [2:0] syndrome(input logic [6:0] c);
      syndrome[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      syndrome[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      syndrome[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
   endfunction

   function automatic logic [3:0] correct_data(input logic [6:0] c);
      logic [6:0] f;
      logic [2:0] s;
      f = c;
      s = syndrome(c);
      if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
      return {f[6:4], f[2]};
   endfunction

   logic [6:0] s, sf, v;
   int         t_prev, t_now;

   initial begin
      drive(0, 1'b0, 4'd0, 3'd0);
      drive(1, 1'b0, 4'd0, 3'd0);
      drive(2, 1'b0, 4'd0, 3'd0);
      ref_w = 4'd0;

      // Reset values while rst is asserted
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ia.in_ready}, 32'd0);
      chk("rst_valid", {31'd0, ia.tx_valid}, 32'd0);
      chk("rst_bit",   {31'd0, ia.tx_bit},   32'd0);
      chk("rst_sof",   {31'd0, ia.tx_sof},   32'd0);
      chk("rst_code",  {25'd0, ia.code},     32'd0);
      chk("rst_fcnt",  {24'd0, ia.frame_count}, 32'd0);
      rst = 1'b0;
      #1 chk("ready_after_rst", {31'd0, ia.in_ready}, 32'd1);
      @(negedge clk);

      // Frame 1: w=1011, no injection
      wait_ready(0);
      drive(0, 1'b1, 4'b1011, 3'd0);
      @(negedge clk);
      drive(0, 1'b0, 4'b0000, 3'd0);
      collect(0, s, sf, v);
      chk("f1_valid", {25'd0, v},  32'h7f);
      chk("f1_sof",   {25'd0, sf}, 32'h01);
      chk("f1_bits",  {25'd0, s},  32'h55);          // 1,0,1,0,1,0,1
      chk("f1_code",  {25'd0, ia.code}, 32'h55);     // 7'b1010101
      @(negedge clk);
      chk("f1_fcnt",  {24'd0, ia.frame_count}, 32'd1);
      chk("f1_idle_valid", {31'd0, ia.tx_valid}, 32'd0);
      chk("f1_idle_bit",   {31'd0, ia.tx_bit},   32'd0);

      // Frame 2: inject position 3, decode the received stream
      wait_ready(0);
      drive(0, 1'b1, 4'b1011, 3'd3);
      @(negedge clk);
      drive(0, 1'b0, 4'b0000, 3'd0);
      collect(0, s, sf, v);
      chk("inj3_code", {25'd0, ia.code}, 32'h51);    // 7'b1010001
      chk("inj3_bits", {25'd0, s},       32'h51);
      chk("inj3_syn",  {29'd0, syndrome(s)},     32'd3);
      chk("inj3_data", {28'd0, correct_data(s)}, 32'hb);
      @(negedge clk);
      chk("inj3_fcnt", {24'd0, ia.frame_count}, 32'd2);

      // All 16 words back-to-back, in_valid held high
      t_prev = 0;
      for (int k = 0; k < 16; k++) begin
         wait_ready(0);
         t_now = cyc;
         if (k > 0) chk("b2b_period", t_now - t_prev, 32'd9);
         t_prev = t_now;
         drive(0, 1'b1, 4'(k), 3'd0);
         ref_w = 4'(k);
         @(negedge clk);
         if (k == 15) drive(0, 1'b0, 4'd0, 3'd0);
         collect(0, s, sf, v);
         chk("b2b_code", {25'd0, ia.code}, {25'd0, ref_c});
         chk("b2b_bits", {25'd0, s},       {25'd0, ref_c});
         chk("b2b_syn",  {29'd0, syndrome(s)}, 32'd0);
         if (k == 0)  chk("w0_code",  {25'd0, ia.code}, 32'h00);
         if (k == 15) chk("w15_code", {25'd0, ia.code}, 32'h7f);
      end
      @(negedge clk);
      chk("b2b_fcnt", {24'd0, ia.frame_count}, 32'd18);

      // MSB-first instance, inject position 7
      wait_ready(1);
      drive(1, 1'b1, 4'b1011, 3'd7);
      @(negedge clk);
      drive(1, 1'b0, 4'b0000, 3'd0);
      collect(1, s, sf, v);
      chk("msb_code", {25'd0, ib.code}, 32'h15);     // 7'b0010101
      chk("msb_bits", {25'd0, s},       32'h54);     // 0,0,1,0,1,0,1 in time order
      chk("msb_sof",  {25'd0, sf},      32'h01);

      // Reset during the 4th bit of a frame
      rst = 1'b1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      wait_ready(0);
      drive(0, 1'b1, 4'b0110, 3'd0);
      @(negedge clk);
      drive(0, 1'b0, 4'b0000, 3'd0);
      repeat (3) @(negedge clk);
      chk("mid_valid_before", {31'd0, ia.tx_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_valid", {31'd0, ia.tx_valid}, 32'd0);
      chk("mid_code",  {25'd0, ia.code},     32'd0);
      chk("mid_fcnt",  {24'd0, ia.frame_count}, 32'd0);
      chk("mid_ready", {31'd0, ia.in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wait_ready(0);
      drive(0, 1'b1, 4'b1011, 3'd0);
      @(negedge clk);
      drive(0, 1'b0, 4'b0000, 3'd0);
      collect(0, s, sf, v);
      chk("post_rst_valid", {25'd0, v}, 32'h7f);
      chk("post_rst_bits",  {25'd0, s}, 32'h55);
      @(negedge clk);
      chk("post_rst_fcnt", {24'd0, ia.frame_count}, 32'd1);

      // 256 frames with no gap: period 8 and count wrap
      t_prev = 0;
      for (int i = 0; i < 256; i++) begin
         wait_ready(2);
         t_now = cyc;
         if (i > 0) chk("nogap_period", t_now - t_prev, 32'd8);
         if (i == 255) chk("fcnt_255", {24'd0, ic.frame_count}, 32'd255);
         t_prev = t_now;
         drive(2, 1'b1, 4'(i), 3'd0);
         @(negedge clk);
      end
      drive(2, 1'b0, 4'd0, 3'd0);
      repeat (10) @(negedge clk);
      chk("fcnt_wrap", {24'd0, ic.frame_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
